// File: rtl/sqrt_arbiter_if.sv
// Handshake bundle between requesters, the sqrt arbiter and the shared sqrt core.
interface sqrt_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] operand;
    logic [N_REQ-1:0]   gnt;
    logic [N_REQ-1:0]   rsp_valid;
    logic [3:0]         rsp_root;
    logic               rsp_err;
    logic               busy;
    logic               core_start;
    logic [7:0]         core_a;
    logic [3:0]         core_x;
    logic               core_done;
    logic               core_valid;

    modport slave (
        input  req, operand, core_x, core_done, core_valid,
        output gnt, rsp_valid, rsp_root, rsp_err, busy, core_start, core_a
    );

    modport master (
        output req, operand, core_x, core_done, core_valid,
        input  gnt, rsp_valid, rsp_root, rsp_err, busy, core_start, core_a
    );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one sqrt core among N_REQ requesters.
// Latency: req->start 1 cycle, done->rsp_valid 1 cycle; requesters hold req until their rsp_valid pulse.
module sqrt_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    sqrt_arbiter_if.slave  bus
);
    localparam int SELW = $clog2(N_REQ);
    localparam int CNTW = $clog2(TIMEOUT);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [SELW-1:0]  last_q, last_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [3:0]       rsp_root_q, rsp_root_d;
    logic             rsp_err_q, rsp_err_d;
    logic             busy_q, busy_d;
    logic             core_start_q, core_start_d;
    logic [7:0]       core_a_q, core_a_d;

    logic [7:0]       op_arr [N_REQ];
    logic [SELW-1:0]  cand_idx;
    logic [SELW-1:0]  pick_idx;
    logic             pick_vld;
    logic             cnt_last;

    for (genvar g = 0; g < N_REQ; g++) begin : g_op
        assign op_arr[g] = bus.operand[8*g+7 : 8*g];
    end

    // Search upward from the slot after the last served requester, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_idx = SELW'((int'(last_q) + k) % N_REQ);
            if (!pick_vld && bus.req[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    assign cnt_last = (cnt_q == CNTW'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        gnt_d        = gnt_q;
        rsp_valid_d  = '0;
        rsp_root_d   = rsp_root_q;
        rsp_err_d    = rsp_err_q;
        busy_d       = busy_q;
        core_start_d = 1'b0;
        core_a_d     = core_a_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    sel_d           = pick_idx;
                    core_a_d        = op_arr[pick_idx];
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    core_start_d    = 1'b1;
                    busy_d          = 1'b1;
                    cnt_d           = '0;
                    state_d         = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.core_done) begin
                    rsp_root_d         = bus.core_x;
                    rsp_err_d          = ~bus.core_valid;
                    rsp_valid_d[sel_q] = 1'b1;
                    state_d            = S_RESP;
                end else if (cnt_last) begin
                    rsp_root_d = '0;
                    rsp_err_d  = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // A late done is swallowed here so it cannot be credited to the next requester.
            S_DRAIN: begin
                if (bus.core_done || cnt_last) begin
                    rsp_valid_d[sel_q] = 1'b1;
                    state_d            = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                last_d  = sel_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            last_q       <= SELW'(N_REQ - 1);
            cnt_q        <= '0;
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_root_q   <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            core_start_q <= 1'b0;
            core_a_q     <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_root_q   <= rsp_root_d;
            rsp_err_q    <= rsp_err_d;
            busy_q       <= busy_d;
            core_start_q <= core_start_d;
            core_a_q     <= core_a_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_root   = rsp_root_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.busy       = busy_q;
    assign bus.core_start = core_start_q;
    assign bus.core_a     = core_a_q;
endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter with a behavioural sqrt core stub.
module tb_sqrt_arbiter;
    localparam int N  = 4;
    localparam int TO = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;

    int   core_delay = -1;
    logic core_vcfg  = 1'b1;
    int   core_xovr  = -1;

    sqrt_arbiter_if #(.N_REQ(N)) bus ();

    sqrt_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         idx;
        logic [7:0] opnd;
        int         dly;
        logic       vld;
        int         xovr;
        logic [3:0] eroot;
        logic       eerr;
    } vec_t;

    function automatic logic [3:0] isqrt(input logic [7:0] a);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(a)) r++;
        return 4'(r);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_start(input string nm, input int max, output int c);
        c = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.core_start === 1'b1) begin
                c = cyc;
                break;
            end
        end
        checks++;
        if (c < 0) begin
            failures++;
            $display("FAIL %s: no core_start within %0d cycles", nm, max);
        end
    endtask

    task automatic wait_rsp(input string nm, input int max, output int c);
        c = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== '0) begin
                c = cyc;
                break;
            end
        end
        checks++;
        if (c < 0) begin
            failures++;
            $display("FAIL %s: no rsp_valid within %0d cycles", nm, max);
        end
    endtask

    // Core stub: done pulses core_delay cycles after the start is seen; negative delay means never.
    initial begin
        int         d;
        logic [7:0] a;
        bus.core_done  = 1'b0;
        bus.core_valid = 1'b0;
        bus.core_x     = '0;
        forever begin
            @(negedge clk);
            if (bus.core_start === 1'b1) begin
                d = core_delay;
                a = bus.core_a;
                if (d > 0) begin
                    repeat (d) @(negedge clk);
                    bus.core_x     = (core_xovr >= 0) ? 4'(core_xovr) : isqrt(a);
                    bus.core_valid = core_vcfg;
                    bus.core_done  = 1'b1;
                    @(negedge clk);
                    bus.core_done  = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt [6];
        int   c0, cs, cr, prev_r, bad_busy, lat, seen;
        logic [3:0] rr_root [5];

        vt[0] = '{0, 8'd49,  8, 1'b1, -1, 4'd7,  1'b0};
        vt[1] = '{1, 8'd255, 4, 1'b1, -1, 4'd15, 1'b0};
        vt[2] = '{3, 8'd1,   2, 1'b1, -1, 4'd1,  1'b0};
        vt[3] = '{2, 8'd200, 5, 1'b0,  5, 4'd5,  1'b1};
        vt[4] = '{1, 8'd0,   1, 1'b1, -1, 4'd0,  1'b0};
        vt[5] = '{0, 8'd63,  3, 1'b1, -1, 4'd7,  1'b0};
        rr_root = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd0};

        bus.req     = '0;
        bus.operand = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt",        32'(bus.gnt), 0);
        check("rst_rsp_valid",  32'(bus.rsp_valid), 0);
        check("rst_busy",       32'(bus.busy), 0);
        check("rst_core_start", 32'(bus.core_start), 0);
        check("rst_core_a",     32'(bus.core_a), 0);
        check("rst_rsp_root",   32'(bus.rsp_root), 0);
        check("rst_rsp_err",    32'(bus.rsp_err), 0);
        reset = 1'b0;

        // Round-robin with all four requesting; pointer starts at 3 so requester 0 is first.
        @(negedge clk);
        core_delay = 3; core_vcfg = 1'b1; core_xovr = -1;
        bus.operand = {8'd16, 8'd9, 8'd4, 8'd0};
        bus.req = 4'b1111;
        c0 = cyc;
        prev_r = -1;
        for (int k = 0; k < 5; k++) begin
            wait_start($sformatf("rr%0d_start", k), 20, cs);
            check($sformatf("rr%0d_gnt", k), 32'(bus.gnt), 32'(1 << (k % 4)));
            if (k == 0) check("rr0_start_lat", cs - c0, 1);
            else        check($sformatf("rr%0d_gap", k), cs - prev_r, 2);
            wait_rsp($sformatf("rr%0d_rsp", k), 20, cr);
            check($sformatf("rr%0d_rsp_valid", k), 32'(bus.rsp_valid), 32'(1 << (k % 4)));
            check($sformatf("rr%0d_root", k), 32'(bus.rsp_root), 32'(rr_root[k]));
            check($sformatf("rr%0d_err", k), 32'(bus.rsp_err), 0);
            prev_r = cr;
            if (k == 4) bus.req = '0;
        end
        repeat (3) @(negedge clk);

        // Single-requester vectors.
        for (int v = 0; v < 6; v++) begin
            core_delay = vt[v].dly; core_vcfg = vt[v].vld; core_xovr = vt[v].xovr;
            bus.operand[8*vt[v].idx +: 8] = vt[v].opnd;
            bus.req = 4'(1 << vt[v].idx);
            c0 = cyc;
            wait_start($sformatf("v%0d_start", v), 20, cs);
            check($sformatf("v%0d_start_lat", v), cs - c0, 1);
            check($sformatf("v%0d_gnt", v), 32'(bus.gnt), 32'(1 << vt[v].idx));
            check($sformatf("v%0d_core_a", v), 32'(bus.core_a), 32'(vt[v].opnd));
            check($sformatf("v%0d_busy", v), 32'(bus.busy), 1);
            wait_rsp($sformatf("v%0d_rsp", v), 40, cr);
            bus.req = '0;
            check($sformatf("v%0d_rsp_lat", v), cr - cs, vt[v].dly + 1);
            check($sformatf("v%0d_rsp_valid", v), 32'(bus.rsp_valid), 32'(1 << vt[v].idx));
            check($sformatf("v%0d_resp_gnt", v), 32'(bus.gnt), 32'(1 << vt[v].idx));
            check($sformatf("v%0d_root", v), 32'(bus.rsp_root), 32'(vt[v].eroot));
            check($sformatf("v%0d_err", v), 32'(bus.rsp_err), 32'(vt[v].eerr));
            @(negedge clk);
            check($sformatf("v%0d_idle_gnt", v), 32'(bus.gnt), 0);
            check($sformatf("v%0d_idle_busy", v), 32'(bus.busy), 0);
            check($sformatf("v%0d_pulse_end", v), 32'(bus.rsp_valid), 0);
            check($sformatf("v%0d_root_hold", v), 32'(bus.rsp_root), 32'(vt[v].eroot));
            repeat (2) @(negedge clk);
        end

        // Timeout with no done at all: two full windows, busy throughout.
        core_delay = -1;
        bus.operand[23:16] = 8'd25;
        bus.req = 4'b0100;
        wait_start("to_start", 20, cs);
        bad_busy = 0;
        cr = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) bad_busy++;
            if (bus.rsp_valid !== '0) begin
                cr = cyc;
                break;
            end
        end
        bus.req = '0;
        lat = cr - cs;
        check("to_busy_held", bad_busy, 0);
        check("to_rsp_window", 32'(lat >= 2*TO && lat <= 2*TO + 2), 1);
        check("to_rsp_valid", 32'(bus.rsp_valid), 32'(4'b0100));
        check("to_root", 32'(bus.rsp_root), 0);
        check("to_err", 32'(bus.rsp_err), 1);
        repeat (3) @(negedge clk);

        // Late done lands in DRAIN; pending requester 1 must get its own operation.
        core_delay = 70; core_vcfg = 1'b1; core_xovr = -1;
        bus.operand[7:0]  = 8'd100;
        bus.operand[15:8] = 8'd9;
        bus.req = 4'b0001;
        wait_start("ld_start0", 20, cs);
        bus.req = 4'b0011;
        wait_rsp("ld_rsp0", 100, cr);
        bus.req = 4'b0010;
        core_delay = 5;
        check("ld_rsp0_lat", cr - cs, 71);
        check("ld_rsp0_valid", 32'(bus.rsp_valid), 32'(4'b0001));
        check("ld_rsp0_err", 32'(bus.rsp_err), 1);
        check("ld_rsp0_root", 32'(bus.rsp_root), 0);
        prev_r = cr;
        wait_start("ld_start1", 20, cs);
        check("ld_start1_gap", cs - prev_r, 2);
        check("ld_gnt1", 32'(bus.gnt), 32'(4'b0010));
        check("ld_core_a1", 32'(bus.core_a), 9);
        wait_rsp("ld_rsp1", 20, cr);
        bus.req = '0;
        check("ld_rsp1_lat", cr - cs, 6);
        check("ld_rsp1_valid", 32'(bus.rsp_valid), 32'(4'b0010));
        check("ld_rsp1_root", 32'(bus.rsp_root), 3);
        check("ld_rsp1_err", 32'(bus.rsp_err), 0);
        repeat (3) @(negedge clk);

        // Asynchronous reset three cycles into WAIT.
        core_delay = -1;
        bus.operand[15:8] = 8'd50;
        bus.req = 4'b0010;
        wait_start("rs_start", 20, cs);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rs_gnt", 32'(bus.gnt), 0);
        check("rs_busy", 32'(bus.busy), 0);
        check("rs_core_start", 32'(bus.core_start), 0);
        check("rs_core_a", 32'(bus.core_a), 0);
        bus.req = '0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== '0) seen++;
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== '0) seen++;
        end
        check("rs_no_rsp", seen, 0);
        core_delay = 2; core_vcfg = 1'b1; core_xovr = -1;
        bus.operand[23:16] = 8'd36;
        bus.req = 4'b0100;
        c0 = cyc;
        wait_start("rs_start2", 20, cs);
        check("rs_start2_lat", cs - c0, 1);
        check("rs_gnt2", 32'(bus.gnt), 32'(4'b0100));
        wait_rsp("rs_rsp2", 20, cr);
        bus.req = '0;
        check("rs_rsp2_valid", 32'(bus.rsp_valid), 32'(4'b0100));
        check("rs_rsp2_root", 32'(bus.rsp_root), 6);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
